// File: rtl/hsv_pkg.sv
// hsv_pkg: shared constants, region encoding and hue-sector helpers for hsv_rgb_decoder
package hsv_pkg;
  localparam logic [7:0] SECTOR = 8'd43;
  localparam logic [7:0] REM_SCALE = 8'd6;
  localparam int PIPE_DEPTH = 4;
  typedef enum logic [2:0] {REG_0, REG_1, REG_2, REG_3, REG_4, REG_5} region_e;
  // Hue sector: H/43, which saturates naturally at 5 for H=215..255
  function automatic region_e h_region(input logic [7:0] h);
    h_region = REG_0;
    for (int i = 1; i < 6; i++)
      if (int'(h) >= i * int'(SECTOR)) h_region = region_e'(3'(i));
  endfunction
  // Position inside the sector scaled to 0..252, kept to 8 bits
  function automatic logic [7:0] h_rem(input logic [7:0] h, input region_e r);
    return 8'((int'(h) - int'(r) * int'(SECTOR)) * int'(REM_SCALE));
  endfunction
endpackage

// File: rtl/mul8_shr8.sv
// mul8_shr8: (a*b)>>8 with round-half-up when HSV_DECODE_ROUND_EN is defined
module mul8_shr8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  logic [15:0] prod;
`ifdef HSV_DECODE_ROUND_EN
  assign prod = 16'(a_i) * 16'(b_i) + 16'd128;
`else
  assign prod = 16'(a_i) * 16'(b_i);
`endif
  assign y_o = 8'(prod >> 8);
endmodule

// File: rtl/hsv_rgb_decoder.sv
// hsv_rgb_decoder: 4-stage HSV to RGB pipeline with valid/ready flow control; HSV_DECODE_ROUND_EN selects rounded products
module hsv_rgb_decoder
  import hsv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_hsv,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [23:0] out_rgb,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready
);
  logic                  en;
  logic [PIPE_DEPTH-1:0] vld_q, last_q;
  region_e               reg_d, s1_reg_q, s2_reg_q, s3_reg_q;
  logic [7:0]            s1_rem_q, s1_s_q, s1_v_q;
  logic [7:0]            sr_d, sf_d, s2_sr_q, s2_sf_q, s2_ns_q, s2_v_q;
  logic [7:0]            p_d, q_d, t_d, s3_p_q, s3_q_q, s3_t_q, s3_v_q;
  logic                  s2_gray_q, s3_gray_q;
  logic [23:0]           rgb_mux, rgb_d, rgb_q;
  assign en = !(vld_q[PIPE_DEPTH-1] && !out_ready);
  assign in_ready = en;
  assign out_valid = vld_q[PIPE_DEPTH-1];
  assign out_last = last_q[PIPE_DEPTH-1];
  assign out_rgb = rgb_q;
  assign reg_d = h_region(in_hsv[23:16]);
  mul8_shr8 u_sr (.a_i(s1_s_q), .b_i(s1_rem_q),  .y_o(sr_d));
  mul8_shr8 u_sf (.a_i(s1_s_q), .b_i(~s1_rem_q), .y_o(sf_d));
  mul8_shr8 u_p  (.a_i(s2_v_q), .b_i(s2_ns_q),   .y_o(p_d));
  mul8_shr8 u_q  (.a_i(s2_v_q), .b_i(~s2_sr_q),  .y_o(q_d));
  mul8_shr8 u_t  (.a_i(s2_v_q), .b_i(~s2_sf_q),  .y_o(t_d));
  // Sector-dependent channel assignment; gray pixels bypass it
  always_comb begin
    case (s3_reg_q)
      REG_0:   rgb_mux = {s3_v_q, s3_t_q, s3_p_q};
      REG_1:   rgb_mux = {s3_q_q, s3_v_q, s3_p_q};
      REG_2:   rgb_mux = {s3_p_q, s3_v_q, s3_t_q};
      REG_3:   rgb_mux = {s3_p_q, s3_q_q, s3_v_q};
      REG_4:   rgb_mux = {s3_t_q, s3_p_q, s3_v_q};
      default: rgb_mux = {s3_v_q, s3_p_q, s3_q_q};
    endcase
  end
  assign rgb_d = s3_gray_q ? {3{s3_v_q}} : rgb_mux;
  // Valid/last tags and output register advance together, frozen on downstream stall
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      last_q <= '0;
      rgb_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[PIPE_DEPTH-2:0], in_valid};
      last_q <= {last_q[PIPE_DEPTH-2:0], in_valid && in_last};
      rgb_q <= rgb_d;
    end
  end
  // Datapath stages S1..S3; contents only matter where the matching valid bit is set
  always_ff @(posedge clk) begin
    if (en) begin
      s1_reg_q <= reg_d;
      s1_rem_q <= h_rem(in_hsv[23:16], reg_d);
      s1_s_q <= in_hsv[15:8];
      s1_v_q <= in_hsv[7:0];
      s2_reg_q <= s1_reg_q;
      s2_sr_q <= sr_d;
      s2_sf_q <= sf_d;
      s2_ns_q <= ~s1_s_q;
      s2_v_q <= s1_v_q;
      s2_gray_q <= s1_s_q == 8'd0;
      s3_reg_q <= s2_reg_q;
      s3_p_q <= p_d;
      s3_q_q <= q_d;
      s3_t_q <= t_d;
      s3_v_q <= s2_v_q;
      s3_gray_q <= s2_gray_q;
    end
  end
endmodule

// File: tb/tb_hsv_rgb_decoder.sv
// tb_hsv_rgb_decoder: scoreboard against an arithmetic HSV model plus directed literal vectors
module tb_hsv_rgb_decoder;
  logic        clk = 0;
  logic        reset = 1;
  logic [23:0] in_hsv = '0;
  logic        in_valid = 0;
  logic        in_last = 0;
  logic        in_ready;
  logic [23:0] out_rgb;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int stalls = 0;
  int stray = 0;
  typedef struct {logic [23:0] rgb; logic last;} exp_t;
  exp_t sb[$];
  logic        stall_prev = 0;
  logic [23:0] held_rgb;
  logic        held_last;

  hsv_rgb_decoder dut (
    .clk(clk), .reset(reset), .in_hsv(in_hsv), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_rgb(out_rgb), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [23:0] hsv);
    int h, s, v, rg, rem, p, q, t, rnd, r, g, b;
`ifdef HSV_DECODE_ROUND_EN
    rnd = 128;
`else
    rnd = 0;
`endif
    h = int'(hsv[23:16]);
    s = int'(hsv[15:8]);
    v = int'(hsv[7:0]);
    if (s == 0) return {hsv[7:0], hsv[7:0], hsv[7:0]};
    rg = h / 43;
    rem = ((h - 43 * rg) * 6) % 256;
    p = (v * (255 - s) + rnd) / 256;
    q = (v * (255 - (s * rem + rnd) / 256) + rnd) / 256;
    t = (v * (255 - (s * (255 - rem) + rnd) / 256) + rnd) / 256;
    case (rg)
      0: begin r = v; g = t; b = p; end
      1: begin r = q; g = v; b = p; end
      2: begin r = p; g = v; b = t; end
      3: begin r = p; g = q; b = v; end
      4: begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        stray++;
        chk(0, "unexpected_pixel", out_rgb, 24'h0);
      end else begin
        e = sb.pop_front();
        pops++;
        chk(out_rgb === e.rgb, "rgb", out_rgb, e.rgb);
        chk(out_last === e.last, "last", {23'd0, out_last}, {23'd0, e.last});
      end
    end
    chk(in_ready === !(out_valid && !out_ready), "in_ready_rule", {23'd0, in_ready}, {23'd0, !(out_valid && !out_ready)});
    if (stall_prev && out_valid) begin
      chk(out_rgb === held_rgb, "stall_rgb_stable", out_rgb, held_rgb);
      chk(out_last === held_last, "stall_last_stable", {23'd0, out_last}, {23'd0, held_last});
    end
    stall_prev = out_valid && !out_ready;
    held_rgb = out_rgb;
    held_last = out_last;
    if (reset) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{model(in_hsv), in_last});
  end

  task automatic drive(input logic [23:0] hsv, input logic lst);
    logic acc;
    in_hsv = hsv;
    in_valid = 1;
    in_last = lst;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end while (!acc);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic send_one(input logic [23:0] hsv, input logic [23:0] exp, input string nm);
    int n;
    out_ready = 1;
    drive(hsv, 1'b1);
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(out_valid && n == 4, {nm, "_latency"}, 24'(n), 24'd4);
    chk(out_rgb === exp, nm, out_rgb, exp);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [23:0] pix [10] = '{24'h00FFFF, 24'h2A80C0, 24'h55FF10, 24'h7F4080,
                            24'h90FFFF, 24'hABFFFF, 24'hC81020, 24'hFFFFFF,
                            24'h3300FF, 24'hD6A0E0};

  initial begin
    #200000;
    $display("FAIL timeout got %h want %h", 24'h0, 24'h1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk(out_valid === 0, "reset_out_valid", {23'd0, out_valid}, 24'd0);
    chk(out_last === 0, "reset_out_last", {23'd0, out_last}, 24'd0);
    chk(out_rgb === 24'h0, "reset_out_rgb", out_rgb, 24'h0);
    chk(in_ready === 1, "reset_in_ready", {23'd0, in_ready}, 24'd1);
    reset = 0;
    @(posedge clk);
    #1;
`ifdef HSV_DECODE_ROUND_EN
    send_one(24'h00FFFF, 24'hFF0100, "h0_round");
`else
    send_one(24'h00FFFF, 24'hFF0000, "h0");
    send_one(24'h55FFFF, 24'h03FF00, "h85");
    send_one(24'hABFFFF, 24'h0003FF, "h171");
    send_one(24'hFFFFFF, 24'hFF000F, "h255");
`endif
    send_one(24'h0000C8, 24'hC8C8C8, "gray_h0");
    send_one(24'h6400C8, 24'hC8C8C8, "gray_h100");
    send_one(24'hFF00C8, 24'hC8C8C8, "gray_h255");
    pops = 0;
    stalls = 0;
    fork
      for (int i = 0; i < 10; i++) drive(pix[i], i == 9 || i % 4 == 3);
      for (int k = 0; k < 30; k++) begin
        out_ready = !(k >= 3 && k <= 6);
        @(negedge clk);
        if (!in_ready) stalls++;
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1;
    chk(stalls == 3, "stall_cycles", 24'(stalls), 24'd3);
    chk(pops == 10, "burst_count", 24'(pops), 24'd10);
    chk(sb.size() == 0, "burst_drained", 24'(sb.size()), 24'd0);
    stray = 0;
    drive(24'h10FF80, 1'b0);
    drive(24'h60FF80, 1'b0);
    drive(24'hB0FF80, 1'b1);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk(out_valid === 0, "midreset_out_valid", {23'd0, out_valid}, 24'd0);
    chk(in_ready === 1, "midreset_in_ready", {23'd0, in_ready}, 24'd1);
    repeat (8) @(posedge clk);
    #1;
    chk(stray == 0, "midreset_no_stale", 24'(stray), 24'd0);
`ifdef HSV_DECODE_ROUND_EN
    send_one(24'h00FFFF, 24'hFF0100, "post_reset");
`else
    send_one(24'h00FFFF, 24'hFF0000, "post_reset");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hsv_rgb_decoder.md
HSV_RGB_DECODER -- requirements
Module: hsv_rgb_decoder

Interface
REQ-001 SHALL expose clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL expose reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL expose in_hsv, input, 24 bits: {H,S,V}, 8 bits each; H 0..255 spans 0..360 degrees.
REQ-004 SHALL expose in_valid, input, 1 bit: in_hsv is valid this cycle.
REQ-005 SHALL expose in_last, input, 1 bit: end-of-line marker carried with the pixel.
REQ-006 SHALL expose in_ready, output, 1 bit: the block accepts the pixel this cycle.
REQ-007 SHALL expose out_rgb, output, 24 bits: {R,G,B}, 8 bits each.
REQ-008 SHALL expose out_valid, output, 1 bit: out_rgb is valid this cycle.
REQ-009 SHALL expose out_last, output, 1 bit: in_last of the same pixel.
REQ-010 SHALL expose out_ready, input, 1 bit: downstream accepts the pixel this cycle.

Function
REQ-011 SHALL transfer a pixel in only when in_valid and in_ready are both high, and out only when out_valid and out_ready are both high.
REQ-012 SHALL use a 4-stage pipeline: S1 sector/remainder, S2 saturation products, S3 p/q/t, S4 output mux; latency from input accept to out_valid is 4 cycles when no stall occurs.
REQ-013 SHALL hold every stage when out_valid is high and out_ready is low; in_ready SHALL then be low. Otherwise in_ready SHALL be high, including when stages are empty.
REQ-014 SHALL never drop, duplicate or reorder pixels; each stage has a valid bit that advances with its data.
REQ-015 SHALL compute region = H/43 (0..5; H=255 gives 5) and rem = (H - 43*region)*6, truncated to 8 bits.
REQ-016 SHALL compute p = V*(255-S)>>8, q = V*(255-(S*rem>>8))>>8 and t = V*(255-(S*(255-rem)>>8))>>8, using 16-bit unsigned intermediates.
REQ-017 SHALL map region to {R,G,B} as: 0 → (V,t,p); 1 → (q,V,p); 2 → (p,V,t); 3 → (p,q,V); 4 → (t,p,V); 5 → (V,p,q).
REQ-018 SHALL output (V,V,V) when S==0, regardless of H.
REQ-019 SHALL propagate in_last alongside its pixel with identical latency and stall behaviour.
REQ-020 SHALL keep out_rgb stable while out_valid is high and out_ready is low.

Reset
REQ-021 SHALL clear every stage valid bit on reset; out_valid=0, out_last=0 and out_rgb=24'h000000.
REQ-022 SHALL drive in_ready=1 during the cycle after reset.
REQ-023 SHALL discard all in-flight pixels when reset is asserted mid-stream; no stale pixel may appear afterwards.

Configuration
REQ-024 SHALL round all >>8 products by adding 128 before the shift when HSV_DECODE_ROUND_EN is defined.
REQ-025 SHALL truncate all >>8 products when HSV_DECODE_ROUND_EN is undefined (default); the S==0 rule applies in both builds.

Structure
REQ-026 SHALL place the sector constant (43), the remainder scale (6), pipeline depth (4) and region encoding in shared package hsv_pkg.
REQ-027 SHALL implement the 8x8 multiply with optional rounding as sub-module mul8_shr8, instantiated for each product.

Verification (default build)
REQ-028 SHALL cover: H=0, S=255, V=255 → out_rgb=24'hFF0000, 4 cycles after accept.
REQ-029 SHALL cover: H=85, S=255, V=255 → 24'h03FF00; H=171, S=255, V=255 → 24'h0003FF; H=255, S=255, V=255 → region 5 output.
REQ-030 SHALL cover: S=0, V=200, H in {0,100,255} → 24'hC8C8C8 each.
REQ-031 SHALL cover: 10 back-to-back pixels with out_ready low for cycles 3-6 → in_ready low during the stall; all 10 outputs in order with correct out_last; out_rgb stable while stalled.
REQ-032 SHALL cover: reset asserted with 3 pixels in flight → out_valid=0 next cycle; no pre-reset pixel emerges; a new pixel has 4-cycle latency.
REQ-033 SHALL cover: HSV_DECODE_ROUND_EN build with H=0, S=255, V=255 → 24'hFF0100.
